io_output_buffer: RTL and testbench

//   Byte FIFO between the Hubris core's memory-mapped character-output store path and the external IO consumer.
//   The core pushes one byte per accepted store; the external side sees the head byte first-word-fall-through.
//   The external side pops with io_output_en, using io_buffer_size_avai to know how many bytes are pending.

---
 rtl/io_output_buffer.sv | 79 +++++++
 tb/tb_io_output_buffer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_output_buffer.sv
// Byte FIFO from the core's character-output store path to the external IO consumer, with a first-word-fall-through head.
// Optional saturating rejected-write counter enabled by defining IO_BUFFER_OVERFLOW_CNT_EN.
module io_output_buffer #(
  parameter int unsigned DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_wr_en,
  input  logic [7:0]  cpu_wr_data,
  output logic        cpu_wr_ready,
  output logic [31:0] cpu_free_count,
  input  logic        io_output_en,
  output logic [7:0]  io_output_data,
  output logic [31:0] io_buffer_size_avai,
  output logic [15:0] overflow_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign push  = cpu_wr_en && !full;
  assign pop   = io_output_en && !empty;

  // Pointers and occupancy; ready depends on current count only, so full+pop still rejects the push
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is never cleared; the reset cycle performs no write
  always_ff @(posedge clk) begin
    if (reset && push) mem[wr_ptr] <= cpu_wr_data;
  end

  assign cpu_wr_ready        = !full;
  assign cpu_free_count      = 32'(DEPTH) - 32'(count);
  assign io_buffer_size_avai = 32'(count);
  assign io_output_data      = empty ? 8'h00 : mem[rd_ptr];

`ifdef IO_BUFFER_OVERFLOW_CNT_EN
  logic [15:0] ovf_cnt;

  // Saturating count of cycles where the core stored while the FIFO was full
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_cnt <= 16'h0000;
    end else if (cpu_wr_en && full && (ovf_cnt != 16'hFFFF)) begin
      ovf_cnt <= ovf_cnt + 16'd1;
    end
  end

  assign overflow_count = ovf_cnt;
`else
  assign overflow_count = 16'h0000;
`endif

endmodule

// File: tb/tb_io_output_buffer.sv
// Self-checking bench for io_output_buffer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, and a randomized stall stream.
module tb_io_output_buffer;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_wr_en;
  logic [7:0]  cpu_wr_data;
  logic        cpu_wr_ready;
  logic [31:0] cpu_free_count;
  logic        io_output_en;
  logic [7:0]  io_output_data;
  logic [31:0] io_buffer_size_avai;
  logic [15:0] overflow_count;

  io_output_buffer #(.DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .reset               (reset),
    .cpu_wr_en           (cpu_wr_en),
    .cpu_wr_data         (cpu_wr_data),
    .cpu_wr_ready        (cpu_wr_ready),
    .cpu_free_count      (cpu_free_count),
    .io_output_en        (io_output_en),
    .io_output_data      (io_output_data),
    .io_buffer_size_avai (io_buffer_size_avai),
    .overflow_count      (overflow_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit run_cmp = 1'b0;

  logic [7:0] q[$];        // model FIFO contents, head at index 0
  logic [7:0] exp_log[$];  // bytes the model says were popped
  logic [7:0] dut_log[$];  // bytes the consumer saw on io_output_data when popping
  int unsigned ovf_model = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pop decision and push decision both taken on the pre-edge occupancy
  always @(posedge clk) begin
    int sz;
    sz = q.size();
    if (!reset) begin
      q.delete();
      ovf_model = 0;
    end else begin
      if (io_output_en && sz != 0) exp_log.push_back(q.pop_front());
      if (cpu_wr_en && sz != DEPTH) q.push_back(cpu_wr_data);
      if (cpu_wr_en && sz == DEPTH && ovf_model != 32'hFFFF) ovf_model++;
    end
  end

  // Per-cycle compare on the falling edge; also logs what the consumer samples
  always @(negedge clk) begin
    logic [15:0] exp_ovf;
    if (run_cmp) begin
`ifdef IO_BUFFER_OVERFLOW_CNT_EN
      exp_ovf = 16'(ovf_model);
`else
      exp_ovf = 16'h0000;
`endif
      chk("size", io_buffer_size_avai, 32'(q.size()));
      chk("free", cpu_free_count, 32'(DEPTH - q.size()));
      chk("ready", 32'(cpu_wr_ready), 32'(q.size() != DEPTH));
      chk("data", 32'(io_output_data), (q.size() != 0) ? 32'(q[0]) : 32'h0);
      chk("sum", cpu_free_count + io_buffer_size_avai, 32'(DEPTH));
      chk("overflow", 32'(overflow_count), 32'(exp_ovf));
      if (reset && io_output_en && io_buffer_size_avai != 0) dut_log.push_back(io_output_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [7:0] d, input logic en);
    cpu_wr_en = wr;
    cpu_wr_data = d;
    io_output_en = en;
    step();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    cpu_wr_en = 1'b0;
    while (io_buffer_size_avai != 0 && n < budget) begin
      drive(1'b0, 8'h00, 1'b1);
      n++;
    end
    io_output_en = 1'b0;
    chk("drain_timeout", io_buffer_size_avai, 32'h0);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    cpu_wr_en = 1'b0;
    io_output_en = 1'b0;
    repeat (cycles) step();
    reset = 1'b1;
  endtask

  initial begin
    logic [7:0] hi [3];
    int n, k, bad;
    hi[0] = 8'h48; hi[1] = 8'h69; hi[2] = 8'h0A;
    cpu_wr_data = 8'h00;

    // T1 reset
    do_reset(3);
    run_cmp = 1'b1;
    #4;
    chk("t1_size", io_buffer_size_avai, 32'd0);
    chk("t1_free", cpu_free_count, 32'd64);
    chk("t1_ready", 32'(cpu_wr_ready), 32'd1);
    chk("t1_data", 32'(io_output_data), 32'h00);
    step();

    // T2 ordering "Hi\n"
    for (int i = 0; i < 3; i++) drive(1'b1, hi[i], 1'b0);
    cpu_wr_en = 1'b0;
    chk("t2_size", io_buffer_size_avai, 32'd3);
    chk("t2_head", 32'(io_output_data), 32'h48);
    dut_log.delete();
    n = 0;
    while (io_buffer_size_avai != 0 && n < 10) begin
      drive(1'b0, 8'h00, 1'b1);
      n++;
    end
    io_output_en = 1'b0;
    chk("t2_pops", 32'(n), 32'd3);
    chk("t2_len", 32'(dut_log.size()), 32'd3);
    for (int i = 0; i < 3 && i < dut_log.size(); i++) chk("t2_byte", 32'(dut_log[i]), 32'(hi[i]));
    chk("t2_data_empty", 32'(io_output_data), 32'h00);

    // T3 full
    for (int i = 0; i < 64; i++) drive(1'b1, 8'(i), 1'b0);
    cpu_wr_en = 1'b0;
    chk("t3_ready", 32'(cpu_wr_ready), 32'd0);
    chk("t3_size", io_buffer_size_avai, 32'd64);
    chk("t3_free", cpu_free_count, 32'd0);
    drive(1'b1, 8'h55, 1'b0);
    cpu_wr_en = 1'b0;
    chk("t3_size65", io_buffer_size_avai, 32'd64);
    chk("t3_head", 32'(io_output_data), 32'h00);

    // T4 full + simultaneous push/pop, then retry
    dut_log.delete();
    drive(1'b1, 8'hAA, 1'b1);
    io_output_en = 1'b0;
    cpu_wr_en = 1'b0;
    chk("t4_popped", (dut_log.size() == 1) ? 32'(dut_log[0]) : 32'hDEAD, 32'h00);
    chk("t4_size", io_buffer_size_avai, 32'd63);
    chk("t4_head", 32'(io_output_data), 32'h01);
    drive(1'b1, 8'hAA, 1'b0);
    chk("t4_size_retry", io_buffer_size_avai, 32'd64);
    dut_log.delete();
    drain(100);
    chk("t4_len", 32'(dut_log.size()), 32'd64);
    if (dut_log.size() == 64) begin
      chk("t4_second_last", 32'(dut_log[62]), 32'h3F);
      chk("t4_last", 32'(dut_log[63]), 32'hAA);
    end

    // T5 randomized stream with stalls across pointer wrap
    dut_log.delete();
    exp_log.delete();
    k = 0;
    n = 0;
    while ((k < 200 || io_buffer_size_avai != 0) && n < 4000) begin
      logic wr;
      wr = (k < 200) && ($urandom_range(3) != 0) && cpu_wr_ready;
      drive(wr, 8'(k), ($urandom_range(2) != 0));
      if (wr) k++;
      n++;
    end
    cpu_wr_en = 1'b0;
    io_output_en = 1'b0;
    chk("t5_timeout", 32'(k), 32'd200);
    chk("t5_len", 32'(dut_log.size()), 32'd200);
    chk("t5_model_len", 32'(exp_log.size()), 32'd200);
    bad = 0;
    for (int i = 0; i < dut_log.size() && i < 200; i++) if (dut_log[i] !== 8'(i)) bad++;
    for (int i = 0; i < exp_log.size() && i < 200; i++) if (exp_log[i] !== 8'(i)) bad++;
    chk("t5_stream", 32'(bad), 32'd0);

    // T6 overflow counter after a clean reset
    do_reset(1);
    step();
    for (int i = 0; i < 64; i++) drive(1'b1, 8'(i + 100), 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 8'hEE, 1'b0);
    cpu_wr_en = 1'b0;
`ifdef IO_BUFFER_OVERFLOW_CNT_EN
    chk("t6_overflow", 32'(overflow_count), 32'd5);
`else
    chk("t6_overflow", 32'(overflow_count), 32'd0);
`endif

    // Reset mid-stream at size 10
    drain(100);
    for (int i = 0; i < 10; i++) drive(1'b1, 8'(i + 7), 1'b0);
    chk("t6_size10", io_buffer_size_avai, 32'd10);
    do_reset(1);
    chk("t6_size_after_rst", io_buffer_size_avai, 32'd0);
    chk("t6_data_after_rst", 32'(io_output_data), 32'h00);
    chk("t6_ovf_after_rst", 32'(overflow_count), 32'd0);
    step();
    step();

    run_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
